// File: rtl/branch_commit_queue_pkg.sv
// Shared sizing, op/class codes, FSM state constants and entry payload for the branch commit queue.
package branch_commit_queue_pkg;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned IDXW  = 4;
  localparam int unsigned TAGW  = IDXW + 1;
  localparam int unsigned CNTW  = IDXW + 1;

  // Op codes (operaType encoding)
  localparam logic [5:0] OP_JAL  = 6'd1;
  localparam logic [5:0] OP_JALR = 6'd2;
  localparam logic [5:0] OP_BEQ  = 6'd20;

  // Op classes (operaType encoding)
  localparam logic [2:0] TYPE_ITYPE = 3'd1;
  localparam logic [2:0] TYPE_BTYPE = 3'd4;
  localparam logic [2:0] TYPE_JTYPE = 3'd5;

  localparam logic [31:0] TRUE  = 32'd1;
  localparam logic [31:0] FALSE = 32'd0;

  // Commit FSM states
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] WAIT_RB = 1'b1;

  // Static part of a queue entry, captured at allocation
  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  op;
    logic [2:0]  op_type;
  } bcq_entry_t;

  function automatic logic is_jal(input logic [5:0] op);
    return op == OP_JAL;
  endfunction

  function automatic logic is_jalr(input logic [5:0] op);
    return op == OP_JALR;
  endfunction

endpackage

// File: rtl/branch_commit_queue.sv
// In-order queue of in-flight control-transfer ops: program-order alloc, out-of-order resolve,
// in-order commit to the predictor, wrong-path flush on the predictor's roll_back.
module branch_commit_queue
  import branch_commit_queue_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              alloc_valid,
  input  logic [31:0]       alloc_pc,
  input  logic [5:0]        alloc_op,
  input  logic [2:0]        alloc_op_type,
  input  logic [31:0]       alloc_imm,
  output logic              alloc_ready,
  output logic [TAGW-1:0]   alloc_tag,
  input  logic              res_valid,
  input  logic [TAGW-1:0]   res_tag,
  input  logic              res_taken,
  input  logic [31:0]       res_target,
  output logic              rob_commit,
  output logic [31:0]       rob_pc_commit,
  output logic [5:0]        rob_op_commit,
  output logic [2:0]        rob_op_type,
  output logic [31:0]       rob_result,
  output logic [31:0]       rob_pc_result,
  input  logic              roll_back,
  output logic [CNTW-1:0]   count
);

  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  logic [0:0]      state_q, state_d;
  logic [IDXW-1:0] head_q, tail_q;
  logic            epoch_q;
  logic [DEPTH-1:0] valid_q, done_q, taken_q;
  bcq_entry_t      ent_q    [DEPTH];
  logic [31:0]     target_q [DEPTH];

  logic            pop_c, flush_c, alloc_fire_c, res_apply_c;
  logic [IDXW-1:0] res_idx;
  logic            res_epoch;

  assign res_idx   = res_tag[IDXW-1:0];
  assign res_epoch = res_tag[TAGW-1];

  // Allocation handshake; a pending flush blocks new entries
  assign alloc_ready  = (count != FULL_CNT) && !((state_q == WAIT_RB) && roll_back);
  assign alloc_tag    = {epoch_q, tail_q};
  assign alloc_fire_c = alloc_valid && alloc_ready && rdy_in;

  // Resolution is only accepted for live, unresolved entries of the current epoch
  assign res_apply_c = res_valid && rdy_in && !flush_c && (res_epoch == epoch_q) &&
                       valid_q[res_idx] && !done_q[res_idx];

  // Commit FSM next-state: pop a done head in IDLE, wait one cycle for roll_back after branches
  always_comb begin
    state_d = state_q;
    pop_c   = 1'b0;
    flush_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (rdy_in && valid_q[head_q] && done_q[head_q]) begin
          pop_c = 1'b1;
          if (!is_jal(ent_q[head_q].op)) state_d = WAIT_RB;
        end
      end
      WAIT_RB: begin
        if (rdy_in) begin
          flush_c = roll_back;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointers, status bits and registered commit outputs
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q       <= IDLE;
      head_q        <= '0;
      tail_q        <= '0;
      epoch_q       <= 1'b0;
      count         <= '0;
      valid_q       <= '0;
      done_q        <= '0;
      taken_q       <= '0;
      rob_commit    <= 1'b0;
      rob_pc_commit <= '0;
      rob_op_commit <= '0;
      rob_op_type   <= '0;
      rob_result    <= '0;
      rob_pc_result <= '0;
    end else begin
      state_q    <= state_d;
      rob_commit <= pop_c;
      if (pop_c) begin
        rob_pc_commit <= ent_q[head_q].pc;
        rob_op_commit <= ent_q[head_q].op;
        rob_op_type   <= ent_q[head_q].op_type;
        rob_result    <= taken_q[head_q] ? TRUE : FALSE;
        rob_pc_result <= taken_q[head_q] ? target_q[head_q] : ent_q[head_q].pc + 32'd4;
      end
      if (flush_c) begin
        valid_q <= '0;
        done_q  <= '0;
        head_q  <= tail_q;
        count   <= '0;
        epoch_q <= ~epoch_q;
      end else begin
        if (alloc_fire_c) begin
          valid_q[tail_q] <= 1'b1;
          done_q[tail_q]  <= is_jal(alloc_op);
          taken_q[tail_q] <= is_jal(alloc_op);
          tail_q          <= tail_q + IDXW'(1);
        end
        if (pop_c) begin
          valid_q[head_q] <= 1'b0;
          head_q          <= head_q + IDXW'(1);
        end
        if (res_apply_c) begin
          done_q[res_idx]  <= 1'b1;
          taken_q[res_idx] <= is_jalr(ent_q[res_idx].op) ? 1'b1 : res_taken;
        end
        count <= count + CNTW'(alloc_fire_c) - CNTW'(pop_c);
      end
    end
  end

  // Entry payload storage; only meaningful while the matching valid bit is set
  always_ff @(posedge clk_in) begin
    if (alloc_fire_c) begin
      ent_q[tail_q]    <= '{pc: alloc_pc, op: alloc_op, op_type: alloc_op_type};
      target_q[tail_q] <= alloc_pc + alloc_imm;
    end
    if (res_apply_c) target_q[res_idx] <= res_target;
  end

endmodule

// File: tb/tb_branch_commit_queue.sv
// Directed bench for branch_commit_queue: commit timing, JAL streaming, ordering, flush, full, stall.
module tb_branch_commit_queue;
  import branch_commit_queue_pkg::*;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              rdy_in;
  logic              alloc_valid;
  logic [31:0]       alloc_pc;
  logic [5:0]        alloc_op;
  logic [2:0]        alloc_op_type;
  logic [31:0]       alloc_imm;
  logic              alloc_ready;
  logic [TAGW-1:0]   alloc_tag;
  logic              res_valid;
  logic [TAGW-1:0]   res_tag;
  logic              res_taken;
  logic [31:0]       res_target;
  logic              rob_commit;
  logic [31:0]       rob_pc_commit;
  logic [5:0]        rob_op_commit;
  logic [2:0]        rob_op_type;
  logic [31:0]       rob_result;
  logic [31:0]       rob_pc_result;
  logic              roll_back;
  logic [CNTW-1:0]   count;

  int checks = 0;
  int errors = 0;

  branch_commit_queue dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_op(alloc_op),
    .alloc_op_type(alloc_op_type), .alloc_imm(alloc_imm),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .res_valid(res_valid), .res_tag(res_tag), .res_taken(res_taken), .res_target(res_target),
    .rob_commit(rob_commit), .rob_pc_commit(rob_pc_commit), .rob_op_commit(rob_op_commit),
    .rob_op_type(rob_op_type), .rob_result(rob_result), .rob_pc_result(rob_pc_result),
    .roll_back(roll_back), .count(count)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_alloc(input logic v, input logic [31:0] pc, input logic [5:0] op,
                           input logic [2:0] ty, input logic [31:0] imm);
    alloc_valid = v; alloc_pc = pc; alloc_op = op; alloc_op_type = ty; alloc_imm = imm;
  endtask

  task automatic set_res(input logic v, input logic [TAGW-1:0] tag, input logic tk,
                         input logic [31:0] tgt);
    res_valid = v; res_tag = tag; res_taken = tk; res_target = tgt;
  endtask

  task automatic chk_commit(input string tag, input logic [31:0] pc, input logic [31:0] res,
                            input logic [31:0] pcres);
    chk({tag, "_commit"}, 32'(rob_commit), 32'd1);
    chk({tag, "_pc"}, rob_pc_commit, pc);
    chk({tag, "_result"}, rob_result, res);
    chk({tag, "_pc_result"}, rob_pc_result, pcres);
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; roll_back = 1'b0;
    set_alloc(1'b0, 32'd0, 6'd0, 3'd0, 32'd0);
    set_res(1'b0, '0, 1'b0, 32'd0);
    tick(); tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_commit", 32'(rob_commit), 32'd0);
    chk("rst_pc_result", rob_pc_result, 32'd0);
    rst_in = 1'b1;
    #1;
    chk("rst_ready", 32'(alloc_ready), 32'd1);
    chk("rst_tag", 32'(alloc_tag), 32'd0);

    // 1: single BEQ, resolve taken, commit next cycle, WAIT_RB suppresses following cycle
    set_alloc(1'b1, 32'h100, OP_BEQ, TYPE_BTYPE, 32'd0);
    #1 chk("t1_tag", 32'(alloc_tag), 32'd0);
    tick();
    set_alloc(1'b0, 32'd0, 6'd0, 3'd0, 32'd0);
    chk("t1_count", 32'(count), 32'd1);
    set_res(1'b1, 5'd0, 1'b1, 32'h140);
    tick();
    set_res(1'b0, '0, 1'b0, 32'd0);
    chk("t1_no_early", 32'(rob_commit), 32'd0);
    tick();
    chk_commit("t1", 32'h100, 32'd1, 32'h140);
    chk("t1_optype", 32'(rob_op_type), 32'(TYPE_BTYPE));
    chk("t1_count0", 32'(count), 32'd0);
    tick();
    chk("t1_wait_rb", 32'(rob_commit), 32'd0);

    // 2: two JALs commit back-to-back
    set_alloc(1'b1, 32'h10, OP_JAL, TYPE_JTYPE, 32'd8);
    tick();
    set_alloc(1'b1, 32'h20, OP_JAL, TYPE_JTYPE, 32'd4);
    tick();
    set_alloc(1'b0, 32'd0, 6'd0, 3'd0, 32'd0);
    chk_commit("t2a", 32'h10, 32'd1, 32'h18);
    tick();
    chk_commit("t2b", 32'h20, 32'd1, 32'h24);
    chk("t2_count", 32'(count), 32'd0);
    tick();
    chk("t2_idle", 32'(rob_commit), 32'd0);

    // 3: three branches (tags 3,4,5) resolved youngest first, commit in order
    for (int i = 0; i < 3; i++) begin
      set_alloc(1'b1, 32'h200 + 32'(4 * i), OP_BEQ, TYPE_BTYPE, 32'd0);
      #1 chk("t3_tag", 32'(alloc_tag), 32'(3 + i));
      tick();
    end
    set_alloc(1'b0, 32'd0, 6'd0, 3'd0, 32'd0);
    set_res(1'b1, 5'd5, 1'b0, 32'h0);
    tick();
    chk("t3_hold5", 32'(rob_commit), 32'd0);
    set_res(1'b1, 5'd4, 1'b1, 32'h300);
    tick();
    chk("t3_hold4", 32'(rob_commit), 32'd0);
    set_res(1'b1, 5'd3, 1'b0, 32'h0);
    tick();
    set_res(1'b0, '0, 1'b0, 32'd0);
    chk("t3_hold3", 32'(rob_commit), 32'd0);
    tick();
    chk_commit("t3a", 32'h200, 32'd0, 32'h204);
    tick();
    chk("t3_gap1", 32'(rob_commit), 32'd0);
    tick();
    chk_commit("t3b", 32'h204, 32'd1, 32'h300);
    tick();
    chk("t3_gap2", 32'(rob_commit), 32'd0);
    tick();
    chk_commit("t3c", 32'h208, 32'd0, 32'h20c);
    tick();
    chk("t3_count", 32'(count), 32'd0);

    // 4: roll_back flushes 4 younger entries, epoch toggles, stale tags ignored
    for (int i = 0; i < 5; i++) begin
      set_alloc(1'b1, 32'h400 + 32'(4 * i), OP_BEQ, TYPE_BTYPE, 32'd0);
      tick();
    end
    set_alloc(1'b0, 32'd0, 6'd0, 3'd0, 32'd0);
    chk("t4_count5", 32'(count), 32'd5);
    set_res(1'b1, 5'd6, 1'b1, 32'h500);
    tick();
    set_res(1'b0, '0, 1'b0, 32'd0);
    tick();
    chk_commit("t4", 32'h400, 32'd1, 32'h500);
    chk("t4_count4", 32'(count), 32'd4);
    roll_back = 1'b1;
    set_alloc(1'b1, 32'h480, OP_BEQ, TYPE_BTYPE, 32'd0);
    set_res(1'b1, 5'd7, 1'b1, 32'h0);
    #1 chk("t4_ready_rb", 32'(alloc_ready), 32'd0);
    tick();
    roll_back = 1'b0;
    set_alloc(1'b0, 32'd0, 6'd0, 3'd0, 32'd0);
    set_res(1'b0, '0, 1'b0, 32'd0);
    chk("t4_flush_count", 32'(count), 32'd0);
    chk("t4_new_tag", 32'(alloc_tag), 32'd27);
    set_alloc(1'b1, 32'h600, OP_BEQ, TYPE_BTYPE, 32'd0);
    tick();
    set_alloc(1'b0, 32'd0, 6'd0, 3'd0, 32'd0);
    set_res(1'b1, 5'd11, 1'b1, 32'h0);
    tick();
    set_res(1'b0, '0, 1'b0, 32'd0);
    tick();
    chk("t4_stale_ignored", 32'(rob_commit), 32'd0);
    chk("t4_count1", 32'(count), 32'd1);
    set_res(1'b1, 5'd27, 1'b0, 32'h0);
    tick();
    set_res(1'b0, '0, 1'b0, 32'd0);
    tick();
    chk_commit("t4b", 32'h600, 32'd0, 32'h604);
    tick();

    // 5: fill to 16 (tail wraps), full blocks alloc even in the pop cycle
    for (int i = 0; i < 16; i++) begin
      set_alloc(1'b1, 32'h1000 + 32'(4 * i), OP_BEQ, TYPE_BTYPE, 32'd0);
      tick();
    end
    chk("t5_full_count", 32'(count), 32'd16);
    chk("t5_full_ready", 32'(alloc_ready), 32'd0);
    chk("t5_wrap_tag", 32'(alloc_tag), 32'd28);
    set_alloc(1'b1, 32'h2000, OP_BEQ, TYPE_BTYPE, 32'd0);
    set_res(1'b1, 5'd28, 1'b0, 32'h0);
    tick();
    set_res(1'b0, '0, 1'b0, 32'd0);
    chk("t5_blocked_count", 32'(count), 32'd16);
    chk("t5_pop_cycle_ready", 32'(alloc_ready), 32'd0);
    tick();
    chk_commit("t5", 32'h1000, 32'd0, 32'h1004);
    chk("t5_count15", 32'(count), 32'd15);
    chk("t5_ready_after", 32'(alloc_ready), 32'd1);
    chk("t5_tag_after", 32'(alloc_tag), 32'd28);
    tick();
    set_alloc(1'b0, 32'd0, 6'd0, 3'd0, 32'd0);
    chk("t5_refill", 32'(count), 32'd16);

    // Reset mid-operation clears everything
    rst_in = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_commit", 32'(rob_commit), 32'd0);
    tick();
    rst_in = 1'b1;
    tick();
    chk("post_rst_commit", 32'(rob_commit), 32'd0);
    chk("post_rst_tag", 32'(alloc_tag), 32'd0);

    // 6: rdy_in low freezes commit and alloc
    set_alloc(1'b1, 32'h700, OP_BEQ, TYPE_BTYPE, 32'd0);
    tick();
    set_alloc(1'b0, 32'd0, 6'd0, 3'd0, 32'd0);
    set_res(1'b1, 5'd0, 1'b1, 32'h780);
    tick();
    set_res(1'b0, '0, 1'b0, 32'd0);
    rdy_in = 1'b0;
    set_alloc(1'b1, 32'h800, OP_BEQ, TYPE_BTYPE, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_stall_commit", 32'(rob_commit), 32'd0);
      chk("t6_stall_count", 32'(count), 32'd1);
    end
    set_alloc(1'b0, 32'd0, 6'd0, 3'd0, 32'd0);
    rdy_in = 1'b1;
    tick();
    chk_commit("t6", 32'h700, 32'd1, 32'h780);
    chk("t6_count", 32'(count), 32'd0);
    tick();
    chk("t6_after", 32'(rob_commit), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
